// File: rtl/mul_booth_r4.sv
// mul_booth_r4: sequential radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU
module mul_booth_r4 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] multiplicand,
  input  logic [DW-1:0] multiplier,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);
  localparam int N  = (DW + 2) / 2;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [DW+1:0]   mcand_q, mcand_d;
  logic [DW+2:0]   mplier_q, mplier_d;
  logic [2*DW-1:0] acc_q, acc_d, pp_w;
  logic [DW-1:0]   result_q, result_d;
  logic [DW+2:0]   m1, m2, pp;
  logic            last, mcand_s, mplier_s;
  // Accumulator keeps only the low 2*DW product bits; higher bits never reach the result.
  always_comb begin
    m1       = {mcand_q[DW+1], mcand_q};
    m2       = {mcand_q, 1'b0};
    pp       = (mplier_q[2:0] == 3'b001 || mplier_q[2:0] == 3'b010) ? m1 :
               (mplier_q[2:0] == 3'b011) ? m2 :
               (mplier_q[2:0] == 3'b100) ? -m2 :
               (mplier_q[2:0] == 3'b101 || mplier_q[2:0] == 3'b110) ? -m1 : '0;
    pp_w     = {{(DW-3){pp[DW+2]}}, pp} << {cnt_q, 1'b0};
    last     = cnt_q == CW'(N - 1);
    mcand_s  = ~&op & multiplicand[DW-1];
    mplier_s = ~op[1] & multiplier[DW-1];
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        op_d     = op;
        mcand_d  = {{2{mcand_s}}, multiplicand};
        mplier_d = {{2{mplier_s}}, multiplier, 1'b0};
        acc_d    = '0;
        cnt_d    = '0;
      end
      RUN: begin
        acc_d    = acc_q + pp_w;
        mplier_d = mplier_q >> 2;
        cnt_d    = last ? '0 : cnt_q + CW'(1);
        state_d  = last ? DONE : RUN;
        result_d = !last ? result_q : (op_q == 2'b00) ? acc_d[DW-1:0] : acc_d[2*DW-1:DW];
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_mul_booth_r4.sv
// tb_mul_booth_r4: directed and randomized checks of mul_booth_r4 against a 64-bit product model
module tb_mul_booth_r4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;
  int          checks = 0;
  int          failures = 0;
  mul_booth_r4 #(.DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .multiplicand(a), .multiplier(b),
    .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xa, yb, p;
    xa = (o == 2'b11) ? {32'h0, x} : {{32{x[31]}}, x};
    yb = o[1] ? {32'h0, y} : {{32{y[31]}}, y};
    p  = xa * yb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction
  function automatic logic [31:0] pick();
    logic [31:0] c [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 3)] : $urandom;
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    r = result;
  endtask
  logic [1:0]  d_op  [7] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
  logic [31:0] d_a   [7] = '{32'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
  logic [31:0] d_b   [7] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] d_exp [7] = '{32'h21, 32'h0, 32'h1, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1};
  initial begin
    logic [31:0] r, prev_res;
    logic [31:0] expq [$];
    logic [1:0]  no;
    logic [31:0] na, nb;
    int lat, bc, dones, k;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], r, lat, bc);
      check($sformatf("dir%0d_result", i), r, d_exp[i]);
      check($sformatf("dir%0d_latency", i), lat, 18);
      check($sformatf("dir%0d_busy_cycles", i), bc, 18);
      @(negedge clk);
      check($sformatf("dir%0d_idle_busy", i), busy, 0);
      check($sformatf("dir%0d_idle_done", i), done, 0);
    end
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    lat = 0;
    r = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      end else if (c == 6) start = 1'b0;
      if (done) begin
        dones++;
        r = result;
        lat = c;
      end
    end
    check("busyprot_dones", dones, 1);
    check("busyprot_result", r, 32'h2A);
    check("busyprot_latency", lat, 18);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_op(2'b00, 32'd5, 32'd5, r, lat, bc);
    check("after_rst_result", r, 32'h19);
    check("after_rst_latency", lat, 18);
    prev_res = r;
    @(negedge clk);
    no = 2'($urandom); na = pick(); nb = pick();
    start = 1'b1; op = no; a = na; b = nb;
    expq.push_back(ref_mul(no, na, nb));
    for (int i = 0; i < 2000; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (!done) begin
          check("rand_hold", result, prev_res);
          if (k >= 2) begin
            op = 2'($urandom); a = $urandom; b = $urandom;
          end
        end
      end while (!done && k < 60);
      if (!done) begin
        check("rand_timeout", 0, 1);
        break;
      end
      check($sformatf("rand%0d_result", i), result, expq.pop_front());
      if (i > 0) check($sformatf("rand%0d_spacing", i), k, 19);
      prev_res = result;
      if (i < 1999) begin
        no = 2'($urandom); na = pick(); nb = pick();
        op = no; a = na; b = nb;
        expq.push_back(ref_mul(no, na, nb));
      end else start = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
